// File: rtl/mux_rr_arbiter.sv
// Round-robin select controller for a WIDTH-bit N:1 packet mux.
// A grant is held for a whole packet, or until MAX_BEATS beats have been sent.
module mux_rr_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16,
  localparam int SELW     = (N > 1) ? $clog2(N) : 1,
  localparam int CNTW     = $clog2(MAX_BEATS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic [N-1:0]       gnt,
  output logic [SELW-1:0]    sel,
  output logic               busy,
  output logic               trunc
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              trunc_q, trunc_d;

  logic [SELW-1:0]   pick_s;
  logic              at_limit_s;
  logic              beat_s;
  logic [WIDTH-1:0]  lane_s [N];

  // Lowest offset above 'last' wins; 'last' itself is scanned last.
  function automatic logic [SELW-1:0] rr_pick(input logic [N-1:0]    req,
                                              input logic [SELW-1:0] last);
    logic [SELW-1:0] pick;
    int              idx;
    pick = last;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[idx[SELW-1:0]]) begin
        pick = idx[SELW-1:0];
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Round-robin pick, beat detection and beat-limit flag.
  always_comb begin
    pick_s     = rr_pick(in_valid, ptr_q);
    at_limit_s = (cnt_q == CNTW'(MAX_BEATS - 1));
    beat_s     = out_valid & out_ready;
  end

  // Split the flat data bus into per-requester lanes.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      lane_s[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Combinational datapath: steer the granted requester to the output.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    in_ready  = '0;
    if (state_q == BUSY) begin
      out_valid       = in_valid[sel_q];
      out_data        = lane_s[sel_q];
      out_last        = in_last[sel_q] | at_limit_s;
      in_ready[sel_q] = out_ready;
    end else begin
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      in_ready  = '0;
    end
  end

  // Grant sequencing: arbitrate in IDLE, count beats and release in BUSY.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    trunc_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          state_d = BUSY;
          sel_d   = pick_s;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick_s;
          cnt_d   = '0;
        end else begin
          gnt_d   = '0;
        end
      end
      BUSY: begin
        if (beat_s && out_last) begin
          // sel is kept so the mux stays parked on the last owner.
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q;
          trunc_d = ~in_last[sel_q];
        end else if (beat_s) begin
          cnt_d   = cnt_q + CNTW'(1);
        end else begin
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d == BUSY);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= SELW'(N - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      trunc_q <= trunc_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign busy  = busy_q;
  assign trunc = trunc_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: a vector table on the default instance plus
// hand-written beat-limit (MAX_BEATS=4 instance) and reset-mid-packet sequences.
module tb_mux_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid, in_last;
  logic [3:0]  tag;
  logic [31:0] in_data;
  logic        out_ready;

  logic [3:0]  a_in_ready, a_gnt, b_in_ready, b_gnt;
  logic        a_out_valid, a_out_last, a_busy, a_trunc;
  logic        b_out_valid, b_out_last, b_busy, b_trunc;
  logic [7:0]  a_out_data, b_out_data;
  logic [1:0]  a_sel, b_sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Lane i carries {i, tag} so the selected requester is visible in out_data.
  assign in_data = {4'h3, tag, 4'h2, tag, 4'h1, tag, 4'h0, tag};

  mux_rr_arbiter #(.N(4), .WIDTH(8), .MAX_BEATS(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_last(a_out_last), .out_ready(out_ready), .gnt(a_gnt), .sel(a_sel),
    .busy(a_busy), .trunc(a_trunc)
  );

  mux_rr_arbiter #(.N(4), .WIDTH(8), .MAX_BEATS(4)) u_lim (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_last(b_out_last), .out_ready(out_ready), .gnt(b_gnt), .sel(b_sel),
    .busy(b_busy), .trunc(b_trunc)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] lst;
    logic       ordy;
    logic [3:0] tag;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       trunc;
    logic       ovld;
    logic       olast;
    logic [3:0] irdy;
    logic [7:0] odata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [3:0] vl, input logic [3:0] ls,
                              input logic ordy, input logic [3:0] tg, input logic [3:0] g,
                              input logic [1:0] s, input logic b, input logic t,
                              input logic ov, input logic ol, input logic [3:0] ir,
                              input logic [7:0] od);
    return '{r, vl, ls, ordy, tg, g, s, b, t, ov, ol, ir, od};
  endfunction

  task automatic chk(input string nm, input int row, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] vl, input logic [3:0] ls,
                       input logic ordy, input logic [3:0] tg);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = vl;
    in_last   = ls;
    out_ready = ordy;
    tag       = tg;
    #3;
  endtask

  task automatic check_outs(input string nm, input int row, input logic lim,
                            input logic [3:0] g, input logic [1:0] s, input logic b,
                            input logic t, input logic ov, input logic ol,
                            input logic [3:0] ir, input logic [7:0] od);
    logic [3:0] ag, air;
    logic [1:0] as;
    logic       ab, at, aov, aol;
    logic [7:0] aod;
    if (lim) begin
      ag = b_gnt; as = b_sel; ab = b_busy; at = b_trunc;
      aov = b_out_valid; aol = b_out_last; air = b_in_ready; aod = b_out_data;
    end else begin
      ag = a_gnt; as = a_sel; ab = a_busy; at = a_trunc;
      aov = a_out_valid; aol = a_out_last; air = a_in_ready; aod = a_out_data;
    end
    chk({nm, ".gnt"},       row, 16'(ag),  16'(g));
    chk({nm, ".sel"},       row, 16'(as),  16'(s));
    chk({nm, ".busy"},      row, 16'(ab),  16'(b));
    chk({nm, ".trunc"},     row, 16'(at),  16'(t));
    chk({nm, ".out_valid"}, row, 16'(aov), 16'(ov));
    chk({nm, ".out_last"},  row, 16'(aol), 16'(ol));
    chk({nm, ".in_ready"},  row, 16'(air), 16'(ir));
    chk({nm, ".out_data"},  row, 16'(aod), 16'(od));
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'b0; in_last = 4'b0; out_ready = 1'b0; tag = 4'h0;
    repeat (3) @(posedge clk);

    // reset state, then single 3-beat request from requester 2
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b1, 4'h0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00));
    vecs.push_back(mk(1'b0, 4'b0100, 4'b0000, 1'b1, 4'h1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00));
    vecs.push_back(mk(1'b0, 4'b0100, 4'b0000, 1'b1, 4'h1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100, 8'h21));
    vecs.push_back(mk(1'b0, 4'b0100, 4'b0000, 1'b1, 4'h2, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100, 8'h22));
    vecs.push_back(mk(1'b0, 4'b0100, 4'b0100, 1'b1, 4'h3, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 8'h23));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b1, 4'h0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00));
    // reset, then rotation 0,1,2,3 with single-beat packets
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b1, 4'h0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 4'h5, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 4'h5, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001, 8'h05));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 4'h5, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 4'h5, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0010, 8'h15));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 4'h5, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 4'h5, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 8'h25));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 4'h5, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00));
    vecs.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 4'h5, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 8'h35));
    // wrap-around: after 3, {3,0} pending -> 0, then 3
    vecs.push_back(mk(1'b0, 4'b1001, 4'b1111, 1'b1, 4'h5, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00));
    vecs.push_back(mk(1'b0, 4'b1001, 4'b1111, 1'b1, 4'h5, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001, 8'h05));
    vecs.push_back(mk(1'b0, 4'b1001, 4'b1111, 1'b1, 4'h5, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00));
    vecs.push_back(mk(1'b0, 4'b1001, 4'b1111, 1'b1, 4'h5, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 8'h35));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b1, 4'h0, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00));
    // backpressure and bubbles on requester 1
    vecs.push_back(mk(1'b0, 4'b0010, 4'b0000, 1'b1, 4'h1, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00));
    vecs.push_back(mk(1'b0, 4'b0010, 4'b0000, 1'b1, 4'h1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 8'h11));
    vecs.push_back(mk(1'b0, 4'b0010, 4'b0000, 1'b0, 4'h2, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 8'h12));
    vecs.push_back(mk(1'b0, 4'b0010, 4'b0000, 1'b1, 4'h2, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 8'h12));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b1, 4'h3, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 8'h13));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 4'h3, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h13));
    vecs.push_back(mk(1'b0, 4'b0010, 4'b0010, 1'b1, 4'h3, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0010, 8'h13));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b1, 4'h0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].lst, vecs[i].ordy, vecs[i].tag);
      check_outs("tbl", i, 1'b0, vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].trunc,
                 vecs[i].ovld, vecs[i].olast, vecs[i].irdy, vecs[i].odata);
    end

    // Beat limit (MAX_BEATS=4): requester 0 sends 6 beats without last, 1 pending.
    drive(1'b1, 4'b0000, 4'b0000, 1'b1, 4'h0);
    drive(1'b0, 4'b0011, 4'b0000, 1'b1, 4'h1);
    check_outs("lim", 1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00);
    drive(1'b0, 4'b0011, 4'b0000, 1'b1, 4'h1);
    check_outs("lim", 2, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 8'h01);
    drive(1'b0, 4'b0011, 4'b0000, 1'b0, 4'h2);
    check_outs("lim", 3, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 8'h02);
    drive(1'b0, 4'b0010, 4'b0000, 1'b1, 4'h2);
    check_outs("lim", 4, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 8'h02);
    drive(1'b0, 4'b0011, 4'b0000, 1'b1, 4'h2);
    check_outs("lim", 5, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 8'h02);
    drive(1'b0, 4'b0011, 4'b0000, 1'b1, 4'h3);
    check_outs("lim", 6, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 8'h03);
    drive(1'b0, 4'b0011, 4'b0000, 1'b1, 4'h4);
    check_outs("lim", 7, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001, 8'h04);
    drive(1'b0, 4'b0011, 4'b0000, 1'b1, 4'h5);
    check_outs("lim", 8, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 8'h00);
    drive(1'b0, 4'b0011, 4'b0010, 1'b1, 4'h5);
    check_outs("lim", 9, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0010, 8'h15);
    drive(1'b0, 4'b0011, 4'b0000, 1'b1, 4'h5);
    check_outs("lim", 10, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00);
    drive(1'b0, 4'b0011, 4'b0000, 1'b1, 4'h5);
    check_outs("lim", 11, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 8'h05);
    drive(1'b0, 4'b0011, 4'b0001, 1'b1, 4'h6);
    check_outs("lim", 12, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001, 8'h06);
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 4'h0);
    check_outs("lim", 13, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00);

    // Reset after beat 2 of a packet from requester 2; requester 0 wins afterwards.
    drive(1'b1, 4'b0000, 4'b0000, 1'b1, 4'h0);
    drive(1'b0, 4'b0100, 4'b0000, 1'b1, 4'h1);
    check_outs("rstmid", 1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00);
    drive(1'b0, 4'b0100, 4'b0000, 1'b1, 4'h1);
    check_outs("rstmid", 2, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100, 8'h21);
    drive(1'b0, 4'b0100, 4'b0000, 1'b1, 4'h2);
    check_outs("rstmid", 3, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100, 8'h22);
    drive(1'b1, 4'b0101, 4'b0000, 1'b1, 4'h3);
    check_outs("rstmid", 4, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100, 8'h23);
    drive(1'b0, 4'b0101, 4'b0000, 1'b1, 4'h3);
    check_outs("rstmid", 5, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00);
    drive(1'b0, 4'b0101, 4'b0000, 1'b1, 4'h3);
    check_outs("rstmid", 6, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 8'h03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
